atm_session_ctrl: RTL and testbench



---
 rtl/atm_pkg.sv | 30 +++
 rtl/atm_account_table.sv | 115 +++++++++++
 rtl/atm_session_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: FSM states, operation codes
// and response error codes.
package atm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIND,
    S_GET_PIN,
    S_MENU,
    S_EXEC,
    S_FIND_DEST,
    S_COMMIT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_BALANCE  = 2'd0;
  localparam logic [1:0] OP_WITHDRAW = 2'd1;
  localparam logic [1:0] OP_DEPOSIT  = 2'd2;
  localparam logic [1:0] OP_TRANSFER = 2'd3;

  localparam logic [2:0] ERR_OK         = 3'd0;
  localparam logic [2:0] ERR_NO_ACCOUNT = 3'd1;
  localparam logic [2:0] ERR_BAD_PIN    = 3'd2;
  localparam logic [2:0] ERR_LOCKED     = 3'd3;
  localparam logic [2:0] ERR_NO_FUNDS   = 3'd4;
  localparam logic [2:0] ERR_OVERFLOW   = 3'd5;
  localparam logic [2:0] ERR_BAD_DEST   = 3'd6;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd7;

endpackage

// File: rtl/atm_account_table.sv
// Account table: per-entry account/PIN/balance/lock/try registers, a config
// write port, two balance write ports, and a one-entry-per-cycle search engine.
module atm_account_table
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 8,
  parameter int ACC_W        = 12,
  parameter int PIN_W        = 4,
  parameter int BAL_W        = 11,
  parameter int TRY_W        = 2,
  localparam int IDX_W       = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [ACC_W-1:0] cfg_acc,
  input  logic [PIN_W-1:0] cfg_pin,
  input  logic [BAL_W-1:0] cfg_bal,
  input  logic             search_start,
  input  logic [ACC_W-1:0] search_key,
  output logic             search_found,
  output logic [IDX_W-1:0] search_idx,
  output logic             search_done,
  output logic             search_locked,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PIN_W-1:0] rd_pin,
  output logic [BAL_W-1:0] rd_bal,
  output logic [TRY_W-1:0] rd_tries,
  input  logic [IDX_W-1:0] dst_idx,
  output logic [BAL_W-1:0] dst_bal,
  input  logic             bal_a_we,
  input  logic [IDX_W-1:0] bal_a_idx,
  input  logic [BAL_W-1:0] bal_a_data,
  input  logic             bal_b_we,
  input  logic [IDX_W-1:0] bal_b_idx,
  input  logic [BAL_W-1:0] bal_b_data,
  input  logic             auth_we,
  input  logic [IDX_W-1:0] auth_idx,
  input  logic [TRY_W-1:0] auth_tries,
  input  logic             auth_lock
);

  logic [ACC_W-1:0] acc_reg   [NUM_ACCOUNTS];
  logic [PIN_W-1:0] pin_reg   [NUM_ACCOUNTS];
  logic [BAL_W-1:0] bal_reg   [NUM_ACCOUNTS];
  logic [TRY_W-1:0] tries_reg [NUM_ACCOUNTS];
  logic             valid_reg [NUM_ACCOUNTS];
  logic             lock_reg  [NUM_ACCOUNTS];

  logic [IDX_W-1:0] scan_idx_reg;
  logic [ACC_W-1:0] key_reg;
  logic             busy_reg;
  logic             hit;
  logic             last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg[gi]   <= '0;
          pin_reg[gi]   <= '0;
          bal_reg[gi]   <= '0;
          tries_reg[gi] <= '0;
          valid_reg[gi] <= 1'b0;
          lock_reg[gi]  <= 1'b0;
        end else if (cfg_we && cfg_idx == IDX_W'(gi)) begin
          acc_reg[gi]   <= cfg_acc;
          pin_reg[gi]   <= cfg_pin;
          bal_reg[gi]   <= cfg_bal;
          tries_reg[gi] <= '0;
          valid_reg[gi] <= 1'b1;
          lock_reg[gi]  <= 1'b0;
        end else begin
          // Ports a and b never target the same entry (self-transfer is rejected).
          if (bal_a_we && bal_a_idx == IDX_W'(gi)) bal_reg[gi] <= bal_a_data;
          if (bal_b_we && bal_b_idx == IDX_W'(gi)) bal_reg[gi] <= bal_b_data;
          if (auth_we && auth_idx == IDX_W'(gi)) begin
            tries_reg[gi] <= auth_tries;
            lock_reg[gi]  <= auth_lock;
          end
        end
      end
    end
  endgenerate

  assign hit           = busy_reg && valid_reg[scan_idx_reg] && acc_reg[scan_idx_reg] == key_reg;
  assign last          = scan_idx_reg == IDX_W'(NUM_ACCOUNTS - 1);
  assign search_found  = hit;
  assign search_done   = busy_reg && (hit || last);
  assign search_idx    = scan_idx_reg;
  assign search_locked = lock_reg[scan_idx_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg     <= 1'b0;
      scan_idx_reg <= '0;
      key_reg      <= '0;
    end else if (search_start) begin
      busy_reg     <= 1'b1;
      scan_idx_reg <= '0;
      key_reg      <= search_key;
    end else if (busy_reg) begin
      if (hit || last) busy_reg <= 1'b0;
      else scan_idx_reg <= scan_idx_reg + IDX_W'(1);
    end
  end

  assign rd_pin   = pin_reg[rd_idx];
  assign rd_bal   = bal_reg[rd_idx];
  assign rd_tries = tries_reg[rd_idx];
  assign dst_bal  = bal_reg[dst_idx];

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card lookup, PIN check with lockout, inactivity
// timeout and balance/withdraw/deposit/transfer over a valid/ready channel.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS   = 8,
  parameter int ACC_W          = 12,
  parameter int PIN_W          = 4,
  parameter int BAL_W          = 11,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [ACC_W-1:0] cfg_acc,
  input  logic [PIN_W-1:0] cfg_pin,
  input  logic [BAL_W-1:0] cfg_bal,
  input  logic             card_valid,
  input  logic [ACC_W-1:0] acc_num,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [BAL_W-1:0] amount,
  input  logic [ACC_W-1:0] dest_acc,
  input  logic             exit,
  output logic             rsp_valid,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [BAL_W-1:0] balance,
  output logic             session_active
);

  localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] cur_idx_reg, cur_idx_next, dst_idx_reg, dst_idx_next;
  logic [1:0]       op_reg, op_next;
  logic [BAL_W-1:0] amt_reg, amt_next, balance_reg, balance_next;
  logic [ACC_W-1:0] dest_reg, dest_next;
  logic             exit_pend_reg, exit_pend_next;
  logic [CNT_W-1:0] idle_cnt_reg;
  logic             rsp_valid_reg, rsp_next, error_reg, error_next;
  logic [2:0]       err_code_reg, err_next;

  logic             activity, timeout_hit;
  logic             search_start, search_found, search_done, search_locked;
  logic [ACC_W-1:0] search_key;
  logic [IDX_W-1:0] search_idx, tbl_dst_idx;
  logic [PIN_W-1:0] rd_pin;
  logic [BAL_W-1:0] rd_bal, dst_bal, bal_a_data, bal_b_data;
  logic [TRY_W-1:0] rd_tries, tries_inc, auth_tries;
  logic             bal_a_we, bal_b_we, auth_we, auth_lock;
  logic [BAL_W:0]   dep_sum, dst_sum;

  // COMMIT reads the destination it settled on; FIND_DEST reads the entry under scan.
  assign tbl_dst_idx = (state_reg == S_COMMIT) ? dst_idx_reg : search_idx;

  atm_account_table #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W), .TRY_W(TRY_W)
  ) u_table (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we && state_reg == S_IDLE), .cfg_idx(cfg_idx),
    .cfg_acc(cfg_acc), .cfg_pin(cfg_pin), .cfg_bal(cfg_bal),
    .search_start(search_start), .search_key(search_key), .search_found(search_found),
    .search_idx(search_idx), .search_done(search_done), .search_locked(search_locked),
    .rd_idx(cur_idx_reg), .rd_pin(rd_pin), .rd_bal(rd_bal), .rd_tries(rd_tries),
    .dst_idx(tbl_dst_idx), .dst_bal(dst_bal),
    .bal_a_we(bal_a_we), .bal_a_idx(cur_idx_reg), .bal_a_data(bal_a_data),
    .bal_b_we(bal_b_we), .bal_b_idx(dst_idx_reg), .bal_b_data(bal_b_data),
    .auth_we(auth_we), .auth_idx(cur_idx_reg), .auth_tries(auth_tries), .auth_lock(auth_lock)
  );

  assign timeout_hit = idle_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_next     = state_reg;
    cur_idx_next   = cur_idx_reg;
    dst_idx_next   = dst_idx_reg;
    op_next        = op_reg;
    amt_next       = amt_reg;
    dest_next      = dest_reg;
    exit_pend_next = exit_pend_reg;
    rsp_next       = 1'b0;
    err_next       = err_code_reg;
    balance_next   = balance_reg;
    activity       = 1'b0;
    search_start   = 1'b0;
    search_key     = acc_num;
    dep_sum        = {1'b0, rd_bal} + {1'b0, amt_reg};
    dst_sum        = {1'b0, dst_bal} + {1'b0, amt_reg};
    tries_inc      = rd_tries + TRY_W'(1);
    bal_a_we       = 1'b0;
    bal_a_data     = rd_bal - amt_reg;
    bal_b_we       = 1'b0;
    bal_b_data     = dst_sum[BAL_W-1:0];
    auth_we        = 1'b0;
    auth_tries     = '0;
    auth_lock      = 1'b0;
    if (state_reg inside {S_EXEC, S_FIND_DEST, S_COMMIT} && exit) exit_pend_next = 1'b1;

    case (state_reg)
      S_IDLE: begin
        exit_pend_next = 1'b0;
        if (card_valid) begin
          search_start = 1'b1;
          state_next   = S_FIND;
        end
      end
      S_FIND: begin
        if (search_done) begin
          if (!search_found) begin
            rsp_next = 1'b1; err_next = ERR_NO_ACCOUNT; state_next = S_IDLE;
          end else if (search_locked) begin
            rsp_next = 1'b1; err_next = ERR_LOCKED; state_next = S_IDLE;
          end else begin
            cur_idx_next = search_idx;
            state_next   = S_GET_PIN;
          end
        end
      end
      S_GET_PIN: begin
        if (exit) begin
          state_next = S_DONE;
        end else if (pin_valid) begin
          activity = 1'b1;
          auth_we  = 1'b1;
          if (pin == rd_pin) begin
            state_next = S_MENU;
          end else if (tries_inc >= TRY_W'(MAX_PIN_TRIES)) begin
            auth_tries = tries_inc; auth_lock = 1'b1;
            rsp_next = 1'b1; err_next = ERR_LOCKED; state_next = S_IDLE;
          end else begin
            auth_tries = tries_inc;
            rsp_next = 1'b1; err_next = ERR_BAD_PIN;
          end
        end else if (timeout_hit) begin
          rsp_next = 1'b1; err_next = ERR_TIMEOUT; state_next = S_DONE;
        end
      end
      S_MENU: begin
        if (exit || exit_pend_reg) begin
          state_next = S_DONE;
        end else if (op_valid) begin
          activity   = 1'b1;
          op_next    = op_code;
          amt_next   = amount;
          dest_next  = dest_acc;
          state_next = S_EXEC;
        end else if (timeout_hit) begin
          rsp_next = 1'b1; err_next = ERR_TIMEOUT; state_next = S_DONE;
        end
      end
      S_EXEC: begin
        rsp_next     = 1'b1;
        err_next     = ERR_OK;
        balance_next = rd_bal;
        state_next   = S_MENU;
        case (op_reg)
          OP_WITHDRAW: begin
            if (amt_reg > rd_bal) err_next = ERR_NO_FUNDS;
            else begin bal_a_we = 1'b1; balance_next = bal_a_data; end
          end
          OP_DEPOSIT: begin
            bal_a_data = dep_sum[BAL_W-1:0];
            if (dep_sum[BAL_W]) err_next = ERR_OVERFLOW;
            else begin bal_a_we = 1'b1; balance_next = bal_a_data; end
          end
          OP_TRANSFER: begin
            if (amt_reg > rd_bal) err_next = ERR_NO_FUNDS;
            else begin
              rsp_next = 1'b1 ^ 1'b1; search_start = 1'b1; search_key = dest_reg;
              balance_next = balance_reg; state_next = S_FIND_DEST;
            end
          end
          default: ;
        endcase
      end
      S_FIND_DEST: begin
        if (search_done) begin
          rsp_next = 1'b1; balance_next = rd_bal; state_next = S_MENU;
          if (!search_found || search_idx == cur_idx_reg) err_next = ERR_BAD_DEST;
          else if (dst_sum[BAL_W]) err_next = ERR_OVERFLOW;
          else begin
            rsp_next = 1'b0; balance_next = balance_reg;
            dst_idx_next = search_idx; state_next = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        bal_a_we = 1'b1; bal_b_we = 1'b1;
        rsp_next = 1'b1; err_next = ERR_OK; balance_next = bal_a_data;
        state_next = S_MENU;
      end
      S_DONE: begin
        exit_pend_next = 1'b0;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    error_next = rsp_next ? (err_next != ERR_OK) : error_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cur_idx_reg   <= '0;
      dst_idx_reg   <= '0;
      op_reg        <= '0;
      amt_reg       <= '0;
      dest_reg      <= '0;
      exit_pend_reg <= 1'b0;
      idle_cnt_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      error_reg     <= 1'b0;
      err_code_reg  <= '0;
      balance_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cur_idx_reg   <= cur_idx_next;
      dst_idx_reg   <= dst_idx_next;
      op_reg        <= op_next;
      amt_reg       <= amt_next;
      dest_reg      <= dest_next;
      exit_pend_reg <= exit_pend_next;
      idle_cnt_reg  <= (state_next != state_reg || activity) ? '0 : idle_cnt_reg + CNT_W'(1);
      rsp_valid_reg <= rsp_next;
      error_reg     <= error_next;
      err_code_reg  <= err_next;
      balance_reg   <= balance_next;
    end
  end

  assign op_ready       = state_reg == S_MENU;
  assign session_active = state_reg inside {S_GET_PIN, S_MENU, S_EXEC};
  assign rsp_valid      = rsp_valid_reg;
  assign error          = error_reg;
  assign err_code       = err_code_reg;
  assign balance        = balance_reg;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed walk through the ATM session scenarios followed by randomized
// sessions, each checked against a table-level reference model.
module tb_atm_session_ctrl;

  localparam int NACC = 4, ACC_W = 12, PIN_W = 4, BAL_W = 11, MAXT = 3, TOUT = 40;
  localparam int IDX_W = $clog2(NACC);
  localparam int BMAX = (1 << BAL_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 0; logic [IDX_W-1:0] cfg_idx = '0;
  logic [ACC_W-1:0] cfg_acc = '0; logic [PIN_W-1:0] cfg_pin = '0; logic [BAL_W-1:0] cfg_bal = '0;
  logic card_valid = 0; logic [ACC_W-1:0] acc_num = '0;
  logic pin_valid = 0; logic [PIN_W-1:0] pin = '0;
  logic op_valid = 0, op_ready; logic [1:0] op_code = '0;
  logic [BAL_W-1:0] amount = '0; logic [ACC_W-1:0] dest_acc = '0;
  logic exit = 0, rsp_valid, error, session_active;
  logic [2:0] err_code; logic [BAL_W-1:0] balance;

  atm_session_ctrl #(.NUM_ACCOUNTS(NACC), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
                     .MAX_PIN_TRIES(MAXT), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_acc(cfg_acc),
    .cfg_pin(cfg_pin), .cfg_bal(cfg_bal), .card_valid(card_valid), .acc_num(acc_num),
    .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .amount(amount), .dest_acc(dest_acc), .exit(exit),
    .rsp_valid(rsp_valid), .error(error), .err_code(err_code), .balance(balance),
    .session_active(session_active));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int m_acc[NACC], m_pin[NACC], m_bal[NACC], m_tries[NACC];
  bit m_valid[NACC], m_lock[NACC];
  int cur = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(); @(posedge clk); #1; endtask

  task automatic model_clear();
    for (int j = 0; j < NACC; j++) begin
      m_acc[j] = 0; m_pin[j] = 0; m_bal[j] = 0; m_tries[j] = 0; m_valid[j] = 0; m_lock[j] = 0;
    end
  endtask

  task automatic wait_rsp(input int maxc, output int lat);
    lat = -1;
    for (int i = 0; i <= maxc; i++) begin
      if (rsp_valid === 1'b1) begin lat = i; break; end
      cycle();
    end
  endtask

  // exp_lat < 0 means "any latency from 1 to NACC+2".
  task automatic expect_rsp(input string tag, input int lat, input int exp_lat, input int exp_err, input int exp_bal);
    if (exp_lat < 0) check({tag, "_lat_bound"}, (lat >= 1 && lat <= NACC + 2), 1);
    else check({tag, "_lat"}, lat, exp_lat);
    if (lat >= 0) begin
      check({tag, "_err_code"}, err_code, exp_err);
      check({tag, "_error"}, error, exp_err != 0);
      if (exp_bal >= 0) check({tag, "_balance"}, balance, exp_bal);
    end
  endtask

  task automatic cfg(input int idx, input int a, input int p, input int b);
    cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_acc = ACC_W'(a); cfg_pin = PIN_W'(p); cfg_bal = BAL_W'(b);
    cycle(); cfg_we = 0;
    m_acc[idx] = a; m_pin[idx] = p; m_bal[idx] = b; m_valid[idx] = 1; m_lock[idx] = 0; m_tries[idx] = 0;
  endtask

  task automatic login(input int a, output bit got);
    int k, lat;
    k = -1; got = 0;
    for (int j = 0; j < NACC; j++) if (k < 0 && m_valid[j] && m_acc[j] == a) k = j;
    card_valid = 1; acc_num = ACC_W'(a); cycle(); card_valid = 0;
    if (k < 0) begin
      wait_rsp(NACC + 2, lat); expect_rsp("no_account", lat, NACC, 1, -1);
      check("no_account_idle", session_active, 0);
    end else if (m_lock[k]) begin
      wait_rsp(NACC + 2, lat); expect_rsp("locked_card", lat, k + 1, 3, -1);
      check("locked_card_idle", session_active, 0);
    end else begin
      lat = -1;
      for (int i = 0; i <= NACC + 2; i++) begin
        if (session_active === 1'b1) begin lat = i; break; end
        cycle();
      end
      check("login_lat", lat, k + 1);
      cur = k; got = (lat >= 0);
    end
  endtask

  // st: 0 back in idle, 1 still waiting for PIN, 2 in menu
  task automatic enter_pin(input int p, output int st);
    int lat;
    pin_valid = 1; pin = PIN_W'(p); cycle(); pin_valid = 0;
    if (p == m_pin[cur]) begin
      m_tries[cur] = 0; st = 2;
      check("pin_ok_ready", op_ready, 1);
      check("pin_ok_norsp", rsp_valid, 0);
    end else begin
      m_tries[cur]++;
      wait_rsp(2, lat);
      if (m_tries[cur] >= MAXT) begin
        m_lock[cur] = 1; st = 0;
        expect_rsp("pin_lock", lat, 0, 3, -1);
        check("pin_lock_idle", session_active, 0);
      end else begin
        st = 1;
        expect_rsp("bad_pin", lat, 0, 2, -1);
      end
    end
  endtask

  function automatic void model_op(input int op, input int amt, input int dst, output int e, output int nb);
    int b, d;
    b = m_bal[cur]; e = 0; d = -1;
    case (op)
      1: if (amt > b) e = 4; else m_bal[cur] = b - amt;
      2: if (b + amt > BMAX) e = 5; else m_bal[cur] = b + amt;
      3: begin
        if (amt > b) e = 4;
        else begin
          for (int j = 0; j < NACC; j++) if (d < 0 && m_valid[j] && m_acc[j] == dst) d = j;
          if (d < 0 || d == cur) e = 6;
          else if (m_bal[d] + amt > BMAX) e = 5;
          else begin m_bal[cur] = b - amt; m_bal[d] = m_bal[d] + amt; end
        end
      end
      default: ;
    endcase
    nb = m_bal[cur];
  endfunction

  task automatic do_op(input string tag, input int op, input int amt, input int dst, input bit exit_mid);
    int e, nb, lat;
    model_op(op, amt, dst, e, nb);
    op_valid = 1; op_code = 2'(op); amount = BAL_W'(amt); dest_acc = ACC_W'(dst);
    cycle(); op_valid = 0; exit = exit_mid;
    cycle(); exit = 0;
    wait_rsp(NACC + 3, lat);
    if (lat >= 0) lat = lat + 1;
    expect_rsp(tag, lat, (op == 3 && e != 4) ? -1 : 1, e, nb);
  endtask

  task automatic do_exit();
    exit = 1; cycle(); exit = 0;
    check("exit_inactive", session_active, 0);
    check("exit_norsp", rsp_valid, 0);
    cycle();
    check("exit_not_ready", op_ready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got; int st, lat, seen, a, nops;
    model_clear();
    cycle(); cycle(); rst = 0;
    check("rst_op_ready", op_ready, 0); check("rst_rsp_valid", rsp_valid, 0);
    check("rst_error", error, 0); check("rst_err_code", err_code, 0);
    check("rst_balance", balance, 0); check("rst_session", session_active, 0);

    cfg(0, 2178, 4, 500); cfg(1, 2816, 6, 1000);
    login(2278, got);
    login(2178, got); enter_pin(4, st);
    do_op("withdraw_100", 1, 100, 0, 0);
    do_op("withdraw_2000", 1, 2000, 0, 0);
    do_op("transfer_50", 3, 50, 2816, 0);
    do_exit();
    login(2816, got); enter_pin(6, st);
    do_op("balance_2816", 0, 0, 0, 0);
    do_op("self_transfer", 3, 10, 2816, 0);
    // exit and op_valid together: the op must be dropped
    op_valid = 1; op_code = 2'd0; exit = 1; cycle(); op_valid = 0; exit = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin if (rsp_valid === 1'b1) seen++; cycle(); end
    check("exit_wins_norsp", seen, 0); check("exit_wins_inactive", session_active, 0);

    login(2178, got); enter_pin(4, st);
    do_op("deposit_1800", 2, 1800, 0, 0);
    do_op("deposit_500_exit", 2, 500, 0, 1);
    cycle(); check("late_exit_inactive", session_active, 0);
    cycle(); check("late_exit_idle", op_ready, 0);

    login(2178, got); enter_pin(5, st); enter_pin(5, st); enter_pin(5, st);
    login(2178, got);
    cfg(0, 2178, 4, 850);
    login(2178, got); enter_pin(4, st);
    check("relogin_menu", st, 2);

    wait_rsp(TOUT + 2, lat); expect_rsp("timeout", lat, TOUT, 7, -1);
    cycle(); check("timeout_inactive", session_active, 0);
    cycle();

    login(2178, got); enter_pin(4, st);
    op_valid = 1; op_code = 2'd3; amount = 11'd20; dest_acc = 12'd2816;
    cycle(); op_valid = 0; cycle();
    check("find_dest_norsp", rsp_valid, 0);
    rst = 1; cycle(); cycle(); rst = 0;
    model_clear();
    check("midrst_rsp", rsp_valid, 0); check("midrst_session", session_active, 0);
    check("midrst_balance", balance, 0); check("midrst_ready", op_ready, 0);
    login(2178, got);

    for (int j = 0; j < NACC; j++)
      cfg(j, 100 + j * 500 + int'($urandom_range(0, 99)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, BMAX)));
    for (int s = 0; s < 10; s++) begin
      a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4095)) : m_acc[$urandom_range(0, NACC - 1)];
      login(a, got);
      if (got) begin
        st = 1;
        if ($urandom_range(0, 2) == 0) enter_pin((m_pin[cur] + 1) % 16, st);
        if (st == 1) enter_pin(m_pin[cur], st);
        if (st == 2) begin
          nops = int'($urandom_range(3, 6));
          for (int o = 0; o < nops; o++)
            do_op("rand_op", int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, BMAX)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : m_acc[$urandom_range(0, NACC - 1)],
                  0);
          do_exit();
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
